lcd_bus_reader: RTL and testbench
=================================

Name: lcd_bus_reader

Overview:
- HD44780-style LCD bus read engine; the read-side counterpart of the LCD initializer/writer.
- Executes read cycles (RW=1) to fetch either:
  - the busy flag and address counter (RS=0), or
  - a byte of DDRAM/CGRAM data (RS=1).
- Optionally polls the busy flag until it clears.
- Sits in the LCD controller top beside the writer; the top muxes the LCD control pins and tri-states the data bus while Bus_Release=1.

Parameters:
- T_AS, 2, address setup cycles before E rises (≥1; 40 ns at 50 MHz)
- T_EH, 13, E-high cycles (≥1; ≥230 ns, data valid before last cycle)
- T_EL, 13, E-low recovery cycles after E falls (≥1; completes ≥500 ns E cycle)
- TIMEOUT_CYC, 100000, poll timeout in cycles (used only with LCD_READ_TIMEOUT_EN)

Ports:
- Clock  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- Req  in  1  start a read; sampled only while Ready=1
- Reg_Sel  in  1  0 = busy/address read, 1 = data read; latched at accept
- Wait_Busy  in  1  1 = repeat reads while BF=1; latched at accept; ignored when Reg_Sel=1
- Dados_In  in  8  LCD data bus input (pad input)
- Ready  out  1  idle, can accept Req
- Done  out  1  one-cycle pulse: read sequence complete
- Rd_Data  out  8  last sampled bus byte
- Busy_Flag  out  1  Rd_Data[7]
- Addr_Cnt  out  7  Rd_Data[6:0]
- Timeout  out  1  poll aborted by timeout; sticky until next accept
- LCD_Enable  out  1  LCD E pin
- LCD_RS  out  1  LCD RS pin
- LCD_RW  out  1  LCD RW pin
- Bus_Release  out  1  1 = top must tri-state its Dados drivers

Behaviour:
- Reset values (any cycle, including mid-operation):
  - Ready=1, Done=0, Rd_Data=8'h00, Timeout=0.
  - LCD_Enable=0, LCD_RS=0, LCD_RW=0, Bus_Release=0.
  - State=IDLE, counters=0.
  - Reset mid-read takes effect at the next edge; no Done is issued.
- States: IDLE, SETUP, E_HIGH, E_LOW, DONE.
- IDLE: if Req=1 (call this cycle k), latch Reg_Sel and Wait_Busy&~Reg_Sel, clear Timeout, go to SETUP.
- SETUP, cycles k+1..k+T_AS:
  - Ready=0, LCD_RW=1, LCD_RS=latched Reg_Sel, Bus_Release=1, LCD_Enable=0.
- E_HIGH, next T_EH cycles:
  - LCD_Enable=1.
  - Dados_In is registered into Rd_Data on the last E_HIGH cycle only.
- E_LOW, next T_EL cycles:
  - LCD_Enable=0; RS, RW and Bus_Release are held.
  - On the last cycle: if polling is latched and Rd_Data[7]=1, go to SETUP (new read cycle); otherwise go to DONE.
- DONE, one cycle:
  - Done=1; LCD_RW=0, LCD_RS=0, Bus_Release=0.
  - Ready=1 from the following cycle.
- Single-read latency: Done in cycle k+T_AS+T_EH+T_EL+1 (29 at defaults).
- Each poll iteration adds T_AS+T_EH+T_EL cycles.
- Req while Ready=0 is ignored, not queued.
- Req held high across DONE starts a new read on the first Ready cycle.
- Busy_Flag and Addr_Cnt are combinational slices of the Rd_Data register.
- Rd_Data is stable between updates.
- Phase counters are $clog2(max(T_AS,T_EH,T_EL)+1) bits wide and reload on every state entry.

Optional Feature:
- Macro: LCD_READ_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears at accept and increments every non-IDLE cycle, saturating.
  - Once it is ≥TIMEOUT_CYC, the next E_LOW completion goes to DONE regardless of BF, with Timeout=1.
  - Timeout applies to non-poll reads too; it is harmless there because they finish first.
- Disabled:
  - No counter; polling is unbounded.
  - Timeout tied to 0; TIMEOUT_CYC unused.
  - Port list is identical in both builds.

Decomposition:
- lcd_pkg holds:
  - state encodings;
  - default timing constants (T_AS/T_EH/T_EL at 50 MHz);
  - RS_INSTR=0, RS_DATA=1;
  - BF_BIT=7;
  - the shared LCD pin mux select encodings also used by the writer.
- One sub-module: lcd_phase_timer, a loadable down-counter with a last-cycle flag. It is reused by the writer for E timing.

Test Plan:
1. Reset, then Req=1, Reg_Sel=0, Wait_Busy=0, Dados_In=8'h8A:
   - RS=0, RW=1 from cycle 1; E high cycles 3–15 only.
   - Done at cycle 29; Rd_Data=8'h8A, Busy_Flag=1, Addr_Cnt=7'h0A; Ready=1 at cycle 30.
2. Reg_Sel=1, Wait_Busy=1, Dados_In=8'hC1:
   - RS=1 throughout; exactly one E pulse (no polling).
   - Rd_Data=8'hC1.
3. Poll: Reg_Sel=0, Wait_Busy=1, Dados_In=8'h80 for 3 pulses, then 8'h05:
   - exactly 4 E pulses, one Done at cycle 4·28+1=113;
   - Rd_Data=8'h05; Ready=0 until then.
4. Extra Req pulses at cycles 5 and 20 during a read:
   - ignored; a single Done; no second sequence starts.
5. Reset asserted on cycle 8 (E_HIGH):
   - cycle 9 shows LCD_Enable=0, LCD_RW=0, Bus_Release=0, Ready=1;
   - Done never pulses.
6. LCD_READ_TIMEOUT_EN, TIMEOUT_CYC=200, Dados_In stuck at 8'h80, polling:
   - Done with Timeout=1 at cycle 225 (first E_LOW end ≥200; 8·28+1);
   - next accept clears Timeout.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared HD44780 bus definitions for the LCD reader and writer
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_E_HIGH = 3'd2,
    ST_E_LOW  = 3'd3,
    ST_DONE   = 3'd4
  } lcd_rd_state_t;

  // Pin ownership select used by the controller top to mux E/RS/RW.
  typedef enum logic [1:0] {
    PIN_SEL_IDLE   = 2'd0,
    PIN_SEL_WRITER = 2'd1,
    PIN_SEL_READER = 2'd2
  } lcd_pin_sel_t;

  localparam int LCD_T_AS        = 2;
  localparam int LCD_T_EH        = 13;
  localparam int LCD_T_EL        = 13;
  localparam int LCD_TIMEOUT_CYC = 100000;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  localparam int BF_BIT = 7;

  function automatic int phase_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// rtl/lcd_phase_timer.sv - loadable down-counter flagging the last cycle of a bus phase
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  // A load of N-1 yields a phase of N cycles; last is high on the final one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// rtl/lcd_bus_reader.sv - HD44780 read-cycle engine with optional BF polling; LCD_READ_TIMEOUT_EN bounds polling
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS        = LCD_T_AS,
  parameter int T_EH        = LCD_T_EH,
  parameter int T_EL        = LCD_T_EL,
  parameter int TIMEOUT_CYC = LCD_TIMEOUT_CYC
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req,
  input  logic       Reg_Sel,
  input  logic       Wait_Busy,
  input  logic [7:0] Dados_In,
  output logic       Ready,
  output logic       Done,
  output logic [7:0] Rd_Data,
  output logic       Busy_Flag,
  output logic [6:0] Addr_Cnt,
  output logic       Timeout,
  output logic       LCD_Enable,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       Bus_Release
);

  localparam int PW = phase_width(T_AS, T_EH, T_EL);

  lcd_rd_state_t state;
  logic          poll_q;
  logic          t_load;
  logic [PW-1:0] t_val;
  logic          t_last;
  logic          to_hit;
  logic          go_poll;

  assign Busy_Flag = Rd_Data[BF_BIT];
  assign Addr_Cnt  = Rd_Data[6:0];
  assign go_poll   = poll_q & Rd_Data[BF_BIT] & ~to_hit;

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    unique case (state)
      ST_IDLE: begin
        if (Req) begin
          t_load = 1'b1;
          t_val  = PW'(T_AS - 1);
        end
      end
      ST_SETUP: begin
        if (t_last) begin
          t_load = 1'b1;
          t_val  = PW'(T_EH - 1);
        end
      end
      ST_E_HIGH: begin
        if (t_last) begin
          t_load = 1'b1;
          t_val  = PW'(T_EL - 1);
        end
      end
      ST_E_LOW: begin
        if (t_last) begin
          t_load = 1'b1;
          t_val  = go_poll ? PW'(T_AS - 1) : '0;
        end
      end
      default: begin
        t_load = 1'b0;
        t_val  = '0;
      end
    endcase
  end

  lcd_phase_timer #(.W(PW)) u_phase_timer (
    .clk      (Clock),
    .rst      (Reset),
    .load     (t_load),
    .load_val (t_val),
    .last     (t_last)
  );

`ifdef LCD_READ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cyc_cnt;

  // Saturates at the limit so a stuck BF can never wrap the counter back below it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cyc_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (Req) cyc_cnt <= '0;
    end else if (cyc_cnt < CW'(TIMEOUT_CYC)) begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  assign to_hit = (cyc_cnt >= CW'(TIMEOUT_CYC));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign to_hit             = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      poll_q      <= 1'b0;
      Ready       <= 1'b1;
      Done        <= 1'b0;
      Rd_Data     <= 8'h00;
      Timeout     <= 1'b0;
      LCD_Enable  <= 1'b0;
      LCD_RS      <= 1'b0;
      LCD_RW      <= 1'b0;
      Bus_Release <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (Req) begin
            poll_q      <= Wait_Busy & (Reg_Sel == RS_INSTR);
            Timeout     <= 1'b0;
            Ready       <= 1'b0;
            LCD_RW      <= 1'b1;
            LCD_RS      <= Reg_Sel;
            Bus_Release <= 1'b1;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (t_last) begin
            LCD_Enable <= 1'b1;
            state      <= ST_E_HIGH;
          end
        end
        ST_E_HIGH: begin
          // Sample on the last E-high cycle, once the LCD output has settled.
          if (t_last) begin
            Rd_Data    <= Dados_In;
            LCD_Enable <= 1'b0;
            state      <= ST_E_LOW;
          end
        end
        ST_E_LOW: begin
          if (t_last) begin
            if (go_poll) begin
              state <= ST_SETUP;
            end else begin
              Done        <= 1'b1;
              Timeout     <= to_hit;
              LCD_RW      <= 1'b0;
              LCD_RS      <= 1'b0;
              Bus_Release <= 1'b0;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          Ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb/tb_lcd_bus_reader.sv - directed self-checking bench for lcd_bus_reader
module tb_lcd_bus_reader;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Req;
  logic       Reg_Sel;
  logic       Wait_Busy;
  logic [7:0] Dados_In;
  logic       Ready;
  logic       Done;
  logic [7:0] Rd_Data;
  logic       Busy_Flag;
  logic [6:0] Addr_Cnt;
  logic       Timeout;
  logic       LCD_Enable;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       Bus_Release;

  int n_cmp = 0;
  int n_err = 0;

  int         done_cyc, done_cnt, pulses, first_e, last_e, pin_bad, ready_bad;
  logic       ready_after, to_done, to_c1;
  logic [2:0] done_pins;

  always #5 Clock = ~Clock;

  lcd_bus_reader #(.TIMEOUT_CYC(200)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Req         (Req),
    .Reg_Sel     (Reg_Sel),
    .Wait_Busy   (Wait_Busy),
    .Dados_In    (Dados_In),
    .Ready       (Ready),
    .Done        (Done),
    .Rd_Data     (Rd_Data),
    .Busy_Flag   (Busy_Flag),
    .Addr_Cnt    (Addr_Cnt),
    .Timeout     (Timeout),
    .LCD_Enable  (LCD_Enable),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .Bus_Release (Bus_Release)
  );

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Cycle 0 is the accept cycle; everything is recorded in cycles 1..max_cyc.
  task automatic run_read(input logic rs, input logic wb, input logic [7:0] d_busy,
                          input int n_busy, input logic [7:0] d_free, input int max_cyc,
                          input int req_a, input int req_b);
    int   ended;
    logic prev_e;
    done_cyc = -1; done_cnt = 0; pulses = 0; first_e = -1; last_e = -1;
    pin_bad = 0; ready_bad = 0; ready_after = 1'bx; done_pins = 3'bxxx;
    to_done = 1'bx; to_c1 = 1'bx;
    ended = 0; prev_e = 1'b0;
    Reg_Sel = rs; Wait_Busy = wb;
    Dados_In = (n_busy > 0) ? d_busy : d_free;
    Req = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      tick;
      Req = (c == req_a) || (c == req_b);
      if (c == 1) to_c1 = Timeout;
      if (LCD_Enable && !prev_e) begin
        pulses++;
        if (first_e < 0) first_e = c;
      end
      if (LCD_Enable) last_e = c;
      if (!LCD_Enable && prev_e) begin
        ended++;
        Dados_In = (ended < n_busy) ? d_busy : d_free;
      end
      prev_e = LCD_Enable;
      if (done_cnt == 0 && Ready) ready_bad++;
      if (done_cnt == 0 && !Done && (LCD_RW !== 1'b1 || LCD_RS !== rs || Bus_Release !== 1'b1))
        pin_bad++;
      if (done_cnt == 1 && c == done_cyc + 1) ready_after = Ready;
      if (Done) begin
        done_cnt++;
        done_cyc  = c;
        done_pins = {LCD_RW, LCD_RS, Bus_Release};
        to_done   = Timeout;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Req = 1'b0; Reg_Sel = 1'b0; Wait_Busy = 1'b0; Dados_In = 8'h00;
    tick; tick;
    n_cmp++; if (Ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", Ready); end
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", Done); end
    n_cmp++; if (Rd_Data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data got=%h exp=00", Rd_Data); end
    n_cmp++; if (Timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout got=%b exp=0", Timeout); end
    n_cmp++; if ({LCD_Enable, LCD_RS, LCD_RW, Bus_Release} !== 4'b0000) begin
      n_err++; $display("FAIL rst_pins got=%b exp=0000", {LCD_Enable, LCD_RS, LCD_RW, Bus_Release});
    end
    Reset = 1'b0;
    tick;
  endtask

  task automatic test_single_read;
    run_read(1'b0, 1'b0, 8'h8A, 0, 8'h8A, 35, -1, -1);
    n_cmp++; if (first_e !== 3) begin n_err++; $display("FAIL t1_first_e got=%0d exp=3", first_e); end
    n_cmp++; if (last_e !== 15) begin n_err++; $display("FAIL t1_last_e got=%0d exp=15", last_e); end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL t1_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (pin_bad !== 0) begin n_err++; $display("FAIL t1_pins got=%0d bad cycles exp=0", pin_bad); end
    n_cmp++; if (done_cyc !== 29) begin n_err++; $display("FAIL t1_done_cyc got=%0d exp=29", done_cyc); end
    n_cmp++; if (done_pins !== 3'b000) begin n_err++; $display("FAIL t1_done_pins got=%b exp=000", done_pins); end
    n_cmp++; if (Rd_Data !== 8'h8A) begin n_err++; $display("FAIL t1_rd_data got=%h exp=8a", Rd_Data); end
    n_cmp++; if (Busy_Flag !== 1'b1) begin n_err++; $display("FAIL t1_busy_flag got=%b exp=1", Busy_Flag); end
    n_cmp++; if (Addr_Cnt !== 7'h0A) begin n_err++; $display("FAIL t1_addr_cnt got=%h exp=0a", Addr_Cnt); end
    n_cmp++; if (ready_bad !== 0) begin n_err++; $display("FAIL t1_ready_early got=%0d cycles exp=0", ready_bad); end
    n_cmp++; if (ready_after !== 1'b1) begin n_err++; $display("FAIL t1_ready_30 got=%b exp=1", ready_after); end
  endtask

  task automatic test_data_read;
    run_read(1'b1, 1'b1, 8'hC1, 0, 8'hC1, 35, -1, -1);
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL t2_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (pin_bad !== 0) begin n_err++; $display("FAIL t2_rs_pins got=%0d bad cycles exp=0", pin_bad); end
    n_cmp++; if (done_cyc !== 29) begin n_err++; $display("FAIL t2_done_cyc got=%0d exp=29", done_cyc); end
    n_cmp++; if (Rd_Data !== 8'hC1) begin n_err++; $display("FAIL t2_rd_data got=%h exp=c1", Rd_Data); end
  endtask

  task automatic test_poll;
    run_read(1'b0, 1'b1, 8'h80, 3, 8'h05, 120, -1, -1);
    n_cmp++; if (pulses !== 4) begin n_err++; $display("FAIL t3_pulses got=%0d exp=4", pulses); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL t3_done_cnt got=%0d exp=1", done_cnt); end
    n_cmp++; if (done_cyc !== 113) begin n_err++; $display("FAIL t3_done_cyc got=%0d exp=113", done_cyc); end
    n_cmp++; if (Rd_Data !== 8'h05) begin n_err++; $display("FAIL t3_rd_data got=%h exp=05", Rd_Data); end
    n_cmp++; if (ready_bad !== 0) begin n_err++; $display("FAIL t3_ready_early got=%0d cycles exp=0", ready_bad); end
    n_cmp++; if (pin_bad !== 0) begin n_err++; $display("FAIL t3_pins got=%0d bad cycles exp=0", pin_bad); end
  endtask

  task automatic test_req_ignored;
    run_read(1'b0, 1'b0, 8'h47, 0, 8'h47, 70, 5, 20);
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL t4_done_cnt got=%0d exp=1", done_cnt); end
    n_cmp++; if (done_cyc !== 29) begin n_err++; $display("FAIL t4_done_cyc got=%0d exp=29", done_cyc); end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL t4_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (Rd_Data !== 8'h47) begin n_err++; $display("FAIL t4_rd_data got=%h exp=47", Rd_Data); end
  endtask

  task automatic test_back_to_back;
    int dc, d1, d2;
    dc = 0; d1 = -1; d2 = -1;
    Reg_Sel = 1'b1; Wait_Busy = 1'b0; Dados_In = 8'h5A; Req = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      tick;
      if (c >= 31) Req = 1'b0;
      if (Done) begin
        dc++;
        if (dc == 1) d1 = c; else d2 = c;
      end
    end
    n_cmp++; if (dc !== 2) begin n_err++; $display("FAIL b2b_done_cnt got=%0d exp=2", dc); end
    n_cmp++; if (d1 !== 29) begin n_err++; $display("FAIL b2b_first_done got=%0d exp=29", d1); end
    n_cmp++; if (d2 !== 59) begin n_err++; $display("FAIL b2b_second_done got=%0d exp=59", d2); end
  endtask

  task automatic test_reset_mid;
    int dc;
    dc = 0;
    Reg_Sel = 1'b0; Wait_Busy = 1'b0; Dados_In = 8'h33; Req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      Req = 1'b0;
    end
    n_cmp++; if (LCD_Enable !== 1'b1) begin n_err++; $display("FAIL t5_e_at_8 got=%b exp=1", LCD_Enable); end
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    n_cmp++; if ({LCD_Enable, LCD_RW, Bus_Release, Ready} !== 4'b0001) begin
      n_err++; $display("FAIL t5_pins_at_9 got=%b exp=0001", {LCD_Enable, LCD_RW, Bus_Release, Ready});
    end
    if (Done) dc++;
    for (int c = 10; c <= 50; c++) begin
      tick;
      if (Done) dc++;
    end
    n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL t5_done_cnt got=%0d exp=0", dc); end
    n_cmp++; if (Rd_Data !== 8'h00) begin n_err++; $display("FAIL t5_rd_data got=%h exp=00", Rd_Data); end
  endtask

`ifdef LCD_READ_TIMEOUT_EN
  task automatic test_timeout;
    run_read(1'b0, 1'b1, 8'h80, 100000, 8'h80, 240, -1, -1);
    n_cmp++; if (done_cyc !== 225) begin n_err++; $display("FAIL t6_done_cyc got=%0d exp=225", done_cyc); end
    n_cmp++; if (pulses !== 8) begin n_err++; $display("FAIL t6_pulses got=%0d exp=8", pulses); end
    n_cmp++; if (to_done !== 1'b1) begin n_err++; $display("FAIL t6_timeout got=%b exp=1", to_done); end
    n_cmp++; if (Timeout !== 1'b1) begin n_err++; $display("FAIL t6_timeout_sticky got=%b exp=1", Timeout); end
    run_read(1'b0, 1'b0, 8'h12, 0, 8'h12, 35, -1, -1);
    n_cmp++; if (to_c1 !== 1'b0) begin n_err++; $display("FAIL t6_timeout_clear got=%b exp=0", to_c1); end
    n_cmp++; if (Rd_Data !== 8'h12) begin n_err++; $display("FAIL t6_rd_data got=%h exp=12", Rd_Data); end
  endtask
`else
  task automatic test_timeout;
    run_read(1'b0, 1'b1, 8'h80, 10, 8'h03, 320, -1, -1);
    n_cmp++; if (done_cyc !== 309) begin n_err++; $display("FAIL t6_done_cyc got=%0d exp=309", done_cyc); end
    n_cmp++; if (pulses !== 11) begin n_err++; $display("FAIL t6_pulses got=%0d exp=11", pulses); end
    n_cmp++; if (to_done !== 1'b0) begin n_err++; $display("FAIL t6_timeout got=%b exp=0", to_done); end
    n_cmp++; if (Rd_Data !== 8'h03) begin n_err++; $display("FAIL t6_rd_data got=%h exp=03", Rd_Data); end
  endtask
`endif

  initial begin
    test_reset;
    test_single_read;
    test_data_read;
    test_poll;
    test_req_ignored;
    test_back_to_back;
    test_reset_mid;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
